// File: rtl/riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_muldiv_unit
// Description : Iterative RV32M/RV64M multiply/divide unit (MUL, MULH, MULHSU,
//               MULHU, DIV, DIVU, REM, REMU). Shift-add multiply over a
//               2*XLEN product and restoring division, BITS_PER_CYCLE bits
//               retired per CALC cycle. Valid/ready on both sides; an opaque
//               tag travels with each operation.
// Ports       : clock/reset        clock, asynchronous active-high reset
//               in_valid/in_ready  request handshake (ready only in IDLE)
//               in_funct3          RV M funct3 selecting the operation
//               in_a/in_b/in_tag   rs1, rs2 and tag, latched on accept
//               flush              abandon any in-flight operation
//               out_valid/ready    result handshake
//               out_result/tag     registered result and its tag
//               busy               unit not in IDLE
// Options     : RISCV_MULDIV_EARLY_EXIT_EN - variable-latency early exit
//               (multiply stops when the multiplier runs out of ones, divide
//               skips leading zero groups of the dividend, zero operands
//               short-cut to FIX).
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int N_ITER = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W  = $clog2(N_ITER + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  // acc: multiply -> product accumulator; divide -> {remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc_q, acc_d;
  // opb: multiply -> multiplicand shifted left each cycle; divide -> divisor in low half
  logic [2*XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0]   mpl_q, mpl_d;
  logic              neg_q, neg_d;
  // hold: special-case result preloaded, FIX waits one cycle before publishing
  logic              hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;

  // --------------------------------------------------------------------------
  // Accept-side operand decode
  // --------------------------------------------------------------------------
  logic            w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic            w_div_zero, w_div_ovf, w_zero_op;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_dividend;
  logic [CNT_W-1:0] w_cnt_init;

  assign w_is_div   = in_funct3[2];
  // signed rs1: MULH, MULHSU, DIV, REM; signed rs2: MULH, DIV, REM
  assign w_sgn_a    = in_funct3[2] ? ~in_funct3[0] : (in_funct3[1] ^ in_funct3[0]);
  assign w_sgn_b    = in_funct3[2] ? ~in_funct3[0] : (in_funct3 == 3'd1);
  assign w_neg_a    = w_sgn_a & in_a[XLEN-1];
  assign w_neg_b    = w_sgn_b & in_b[XLEN-1];
  assign w_mag_a    = w_neg_a ? -in_a : in_a;
  assign w_mag_b    = w_neg_b ? -in_b : in_b;
  assign w_div_zero = w_is_div && (in_b == '0);
  assign w_div_ovf  = w_is_div && !in_funct3[0] && (in_a == XMIN) && (&in_b);

`ifdef RISCV_MULDIV_EARLY_EXIT_EN
  logic [CNT_W-1:0] w_lz_groups;
  logic             w_lz_found;

  // Count leading all-zero BITS_PER_CYCLE groups of |a|; those iterations
  // would only shift zeros into the remainder.
  always_comb begin
    w_lz_groups = '0;
    w_lz_found  = 1'b0;
    for (int g = N_ITER - 1; g >= 0; g--) begin
      if (!w_lz_found) begin
        if (w_mag_a[g*BITS_PER_CYCLE +: BITS_PER_CYCLE] == '0) begin
          w_lz_groups = w_lz_groups + CNT_W'(1);
        end else begin
          w_lz_found = 1'b1;
        end
      end
    end
  end

  assign w_dividend = w_mag_a << (w_lz_groups * BITS_PER_CYCLE);
  assign w_cnt_init = CNT_W'(N_ITER) - w_lz_groups;
  assign w_zero_op  = (in_a == '0) || (in_b == '0);
`else
  assign w_dividend = w_mag_a;
  assign w_cnt_init = CNT_W'(N_ITER);
  assign w_zero_op  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // One CALC iteration: BITS_PER_CYCLE chained steps
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_acc_step, w_opb_step;
  logic [XLEN-1:0]   w_mpl_step, w_rem_t, w_quo_t;
  logic [XLEN:0]     w_sh_t, w_diff_t;

  always_comb begin
    w_acc_step = acc_q;
    w_opb_step = opb_q;
    w_mpl_step = mpl_q;
    w_rem_t    = acc_q[2*XLEN-1:XLEN];
    w_quo_t    = acc_q[XLEN-1:0];
    w_sh_t     = '0;
    w_diff_t   = '0;
    if (funct3_q[2]) begin
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
        w_sh_t   = {w_rem_t, w_quo_t[XLEN-1]};
        w_quo_t  = {w_quo_t[XLEN-2:0], 1'b0};
        // bit XLEN of the difference is the borrow: set means restore
        w_diff_t = w_sh_t - {1'b0, opb_q[XLEN-1:0]};
        if (!w_diff_t[XLEN]) begin
          w_rem_t    = w_diff_t[XLEN-1:0];
          w_quo_t[0] = 1'b1;
        end else begin
          w_rem_t = w_sh_t[XLEN-1:0];
        end
      end
      w_acc_step = {w_rem_t, w_quo_t};
    end else begin
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
        if (mpl_q[i]) begin
          w_acc_step = w_acc_step + (opb_q << i);
        end
      end
      w_opb_step = opb_q << BITS_PER_CYCLE;
      w_mpl_step = mpl_q >> BITS_PER_CYCLE;
    end
  end

  // --------------------------------------------------------------------------
  // FIX: sign correction and half / quotient-remainder selection
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_qr_sel, w_div_res, w_fix_result;

  assign w_prod       = neg_q ? -acc_q : acc_q;
  assign w_qr_sel     = funct3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign w_div_res    = neg_q ? -w_qr_sel : w_qr_sel;
  assign w_fix_result = funct3_q[2]          ? w_div_res :
                        (funct3_q == 3'd0)   ? w_prod[XLEN-1:0] :
                                               w_prod[2*XLEN-1:XLEN];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    tag_d        = tag_q;
    acc_d        = acc_q;
    opb_d        = opb_q;
    mpl_d        = mpl_q;
    neg_d        = neg_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          funct3_d = in_funct3;
          tag_d    = in_tag;
          if (w_div_zero || w_div_ovf || w_zero_op) begin
            // Result preloaded as {remainder, quotient} with no sign fix-up.
            hold_d  = 1'b1;
            neg_d   = 1'b0;
            mpl_d   = '0;
            opb_d   = '0;
            acc_d   = w_div_zero ? {in_a, {XLEN{1'b1}}} :
                      w_div_ovf  ? {{XLEN{1'b0}}, XMIN} : '0;
            state_d = S_FIX;
          end else begin
            hold_d  = 1'b0;
            cnt_d   = w_cnt_init;
            opb_d   = {{XLEN{1'b0}}, w_mag_b};
            state_d = S_CALC;
            if (w_is_div) begin
              acc_d = {{XLEN{1'b0}}, w_dividend};
              mpl_d = '0;
              // remainder takes the dividend sign
              neg_d = in_funct3[1] ? w_neg_a : (w_neg_a ^ w_neg_b);
            end else begin
              acc_d = '0;
              mpl_d = w_mag_a;
              neg_d = w_neg_a ^ w_neg_b;
            end
          end
        end
      end
      S_CALC: begin
        acc_d = w_acc_step;
        opb_d = w_opb_step;
        mpl_d = w_mpl_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
`ifdef RISCV_MULDIV_EARLY_EXIT_EN
        if (!funct3_q[2] && (w_mpl_step == '0)) begin
          state_d = S_FIX;
        end
`endif
      end
      S_FIX: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          out_result_d = w_fix_result;
          out_tag_d    = tag_q;
          out_valid_d  = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      hold_d      = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      funct3_q     <= '0;
      tag_q        <= '0;
      acc_q        <= '0;
      opb_q        <= '0;
      mpl_q        <= '0;
      neg_q        <= 1'b0;
      hold_q       <= 1'b0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      tag_q        <= tag_d;
      acc_q        <= acc_d;
      opb_q        <= opb_d;
      mpl_q        <= mpl_d;
      neg_q        <= neg_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_muldiv_unit
// Description : Directed table-driven bench for riscv_muldiv_unit plus
//               hand-written sequences for stall, flush and mid-op reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int BPC   = 1;
  localparam int TAG_W = 5;
  localparam int N     = XLEN / BPC;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_funct3 = '0;
  logic [XLEN-1:0]  in_a = '0;
  logic [XLEN-1:0]  in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int total = 0;
  int bad   = 0;

  riscv_muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]       f3;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  exp;
    bit               special;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Present one request, count edges to out_valid, check result and handoff.
  task automatic run_op(input vec_t v, input int idx);
    int lat;
    bit rdy_seen;
    bit lat_ok;
    @(negedge clock);
    in_valid  = 1'b1;
    in_funct3 = v.f3;
    in_a      = v.a;
    in_b      = v.b;
    in_tag    = v.tag;
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid  = 1'b0;
    // operands scrambled after accept must not matter
    in_a      = $urandom;
    in_b      = $urandom;
    in_funct3 = 3'($urandom);
    in_tag    = TAG_W'($urandom);
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < N + 8) begin
      @(posedge clock); #1;
      lat++;
      if (in_ready) rdy_seen = 1'b1;
    end
    check($sformatf("vec%0d_result", idx), out_result, v.exp);
    check($sformatf("vec%0d_tag", idx), out_tag, v.tag);
`ifdef RISCV_MULDIV_EARLY_EXIT_EN
    lat_ok = v.special ? (lat == 2) : (lat >= 2 && lat <= N + 1);
    check($sformatf("vec%0d_latency_ok", idx), lat_ok, 1);
`else
    lat_ok = 1'b1;
    check($sformatf("vec%0d_latency", idx), lat, v.special ? 2 : N + 1);
`endif
    check($sformatf("vec%0d_in_ready_low", idx), rdy_seen, 0);
    @(posedge clock); #1;
    check($sformatf("vec%0d_handoff", idx), {out_valid, busy}, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   stable_bad;
    bit   seen;
    vec_t v;

    vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 5'h01, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 5'h02, 32'h40000000, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 5'h04, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 5'h05, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 5'h06, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        5'h13, 32'd14,       1'b0};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        5'h07, 32'd2,        1'b0};
    vecs[8]  = '{3'd4, 32'd5,        32'd0,        5'h08, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{3'd6, 32'd5,        32'd0,        5'h09, 32'd5,        1'b1};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'h0A, 32'h80000000, 1'b1};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'h0B, 32'h00000000, 1'b1};
    vecs[12] = '{3'd3, 32'h00010000, 32'h00010000, 5'h0C, 32'h00000001, 1'b0};
    vecs[13] = '{3'd0, 32'h00010000, 32'h00010000, 5'h0D, 32'h00000000, 1'b0};
    vecs[14] = '{3'd1, 32'h80000000, 32'h00000001, 5'h0E, 32'hFFFFFFFF, 1'b0};
    vecs[15] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h0F, 32'h00000000, 1'b0};
    vecs[16] = '{3'd4, 32'h00000007, 32'hFFFFFFFE, 5'h10, 32'hFFFFFFFD, 1'b0};
    vecs[17] = '{3'd6, 32'h00000007, 32'hFFFFFFFE, 5'h11, 32'h00000001, 1'b0};
    vecs[18] = '{3'd6, 32'hFFFFFFF8, 32'hFFFFFFFD, 5'h12, 32'hFFFFFFFE, 1'b0};
    vecs[19] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 5'h14, 32'h00000000, 1'b0};
    vecs[20] = '{3'd7, 32'h80000000, 32'hFFFFFFFF, 5'h15, 32'h80000000, 1'b0};
    vecs[21] = '{3'd5, 32'h00000000, 32'h00000000, 5'h16, 32'hFFFFFFFF, 1'b1};
    vecs[22] = '{3'd7, 32'h00000005, 32'h00000000, 5'h17, 32'h00000005, 1'b1};
    vecs[23] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 5'h18, 32'h80000000, 1'b0};
    vecs[24] = '{3'd4, 32'h80000000, 32'h00000001, 5'h19, 32'h80000000, 1'b0};
    vecs[25] = '{3'd2, 32'h00000002, 32'hFFFFFFFF, 5'h1A, 32'h00000001, 1'b0};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_result", out_result, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;

    // Table of directed operations
    for (int i = 0; i < 26; i++) begin
      run_op(vecs[i], i);
    end

    // Consumer stall: result held 10 cycles, new request ignored until handoff
    @(negedge clock);
    in_valid = 1'b1; in_funct3 = 3'd5; in_a = 32'd100; in_b = 32'd7; in_tag = 5'h13;
    out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int c = 0; c < N + 8 && !out_valid; c++) begin
      @(posedge clock); #1;
    end
    check("stall_first_valid", out_valid, 1);
    stable_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      in_valid = 1'b1; in_funct3 = 3'd0; in_a = 32'd3; in_b = 32'd3; in_tag = 5'h05;
      @(posedge clock); #1;
      if (!out_valid || out_result !== 32'd14 || out_tag !== 5'h13 || in_ready)
        stable_bad++;
    end
    check("stall_stable", stable_bad, 0);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("stall_handoff", {out_valid, busy, in_ready}, 3'b001);

    // Flush at edge E5 of a DIV
    @(negedge clock);
    in_valid = 1'b1; in_funct3 = 3'd4; in_a = 32'hFFFFFFF9; in_b = 32'd2; in_tag = 5'h1E;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_idle", {busy, out_valid, in_ready}, 3'b001);
    seen = 1'b0;
    repeat (N + 4) begin
      @(posedge clock); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    check("flush_no_result", seen, 0);

    // Flush in IDLE blocks an accept
    @(negedge clock);
    in_valid = 1'b1; flush = 1'b1; in_funct3 = 3'd0; in_a = 32'd2; in_b = 32'd2;
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_reject", busy, 0);
    run_op(vecs[6], 6);

    // Reset in the middle of a MUL, then a fresh operation
    @(negedge clock);
    in_valid = 1'b1; in_funct3 = 3'd3; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; in_tag = 5'h1F;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset_outputs", {in_ready, out_valid, busy, out_result, out_tag},
          {1'b1, 1'b0, 1'b0, 32'h0, 5'h0});
    @(negedge clock);
    reset = 1'b0;
    v = vecs[0];
    run_op(v, 0);
    run_op(vecs[4], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
